// File: rtl/hazard_pkg.sv
// Shared state encoding and parameter defaults for the hazard controller.
// The ERROR state exists only when MEM_TIMEOUT_EN is defined.
package hazard_pkg;

    localparam int unsigned WAIT_LIMIT_DEF = 16;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
`ifdef MEM_TIMEOUT_EN
        ,
        ERROR    = 2'b10
`endif
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: a load in EX writes a register that ID is about to read.
module load_use_detect (
    input  logic       mem_rd,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    // $0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = mem_rd & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch/jump flush, load-use bubble.
// Optional MEM_TIMEOUT_EN adds a sticky ERROR state and the mem_timeout port.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRd,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             EX_MEM_MemRd,
    input  logic             EX_MEM_MemWr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_hold,
    output logic [CNT_W-1:0] stall_cnt
`ifdef MEM_TIMEOUT_EN
    ,
    output logic             mem_timeout
`endif
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                mem_acc;
    logic                load_use;
    logic                freeze;
    logic                in_error;

    load_use_detect u_load_use (
        .mem_rd   (ID_EX_MemRd),
        .ex_rt    (ID_EX_Rt),
        .id_rs    (IF_ID_Rs),
        .id_rt    (IF_ID_Rt),
        .load_use (load_use)
    );

    assign mem_acc = EX_MEM_MemRd | EX_MEM_MemWr;
    assign freeze  = mem_acc & ~mem_ready & ((state == RUN) | (state == MEM_WAIT));

`ifdef MEM_TIMEOUT_EN
    logic timeout_hit;
    assign in_error    = (state == ERROR);
    assign timeout_hit = (state == MEM_WAIT) & mem_acc & ~mem_ready
                       & (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));
`else
    assign in_error = 1'b0;
`endif

    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_write = 1'b1;
        ID_EX_flush = 1'b0;
        EX_MEM_hold = 1'b0;
        if (in_error || freeze) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_write = 1'b0;
            EX_MEM_hold = 1'b1;
        end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (jump) begin
            IF_ID_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    // A dropped access request is tolerated by returning to RUN.
                    if (!mem_acc || mem_ready) begin
                        state <= RUN;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state <= ERROR;
                    end
`endif
                    if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                ERROR: state <= ERROR;
`endif
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!PC_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_timeout <= 1'b0;
        end else if (timeout_hit) begin
            mem_timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4, WAIT_LIMIT=4); timeout checks only with MEM_TIMEOUT_EN.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned WL    = 4;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_hold}
    localparam logic [5:0] O_RUN = 6'b110100;
    localparam logic [5:0] O_FRZ = 6'b000001;
    localparam logic [5:0] O_BR  = 6'b111110;
    localparam logic [5:0] O_LU  = 6'b000110;
    localparam logic [5:0] O_JMP = 6'b111100;

    logic             clk;
    logic             reset;
    logic             ID_EX_MemRd;
    logic [4:0]       ID_EX_Rt;
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             EX_MEM_MemRd;
    logic             EX_MEM_MemWr;
    logic             mem_ready;
    logic             branch_taken;
    logic             jump;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_write;
    logic             ID_EX_flush;
    logic             EX_MEM_hold;
    logic [CNT_W-1:0] stall_cnt;
`ifdef MEM_TIMEOUT_EN
    logic             mem_timeout;
`endif
    logic [5:0]       outs;

    int n_tests;
    int n_fail;
    int exp_stall;

    hazard_ctrl #(
        .WAIT_LIMIT (WL),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ID_EX_MemRd  (ID_EX_MemRd),
        .ID_EX_Rt     (ID_EX_Rt),
        .IF_ID_Rs     (IF_ID_Rs),
        .IF_ID_Rt     (IF_ID_Rt),
        .EX_MEM_MemRd (EX_MEM_MemRd),
        .EX_MEM_MemWr (EX_MEM_MemWr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .jump         (jump),
        .PC_write     (PC_write),
        .IF_ID_write  (IF_ID_write),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX_write  (ID_EX_write),
        .ID_EX_flush  (ID_EX_flush),
        .EX_MEM_hold  (EX_MEM_hold),
        .stall_cnt    (stall_cnt)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_timeout  (mem_timeout)
`endif
    );

    assign outs = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_hold};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        ID_EX_MemRd  = 1'b0;
        ID_EX_Rt     = 5'd0;
        IF_ID_Rs     = 5'd0;
        IF_ID_Rt     = 5'd0;
        EX_MEM_MemRd = 1'b0;
        EX_MEM_MemWr = 1'b0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
    endtask

    task automatic set_lu();
        ID_EX_MemRd = 1'b1;
        ID_EX_Rt    = 5'd8;
        IF_ID_Rs    = 5'd8;
        IF_ID_Rt    = 5'd9;
    endtask

    // One rising edge; 'stalled' says whether the inputs held across it stall the PC.
    task automatic tick(input bit stalled);
        @(posedge clk);
        #1;
        if (stalled && exp_stall < 15) exp_stall++;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        exp_stall = 0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_stall = 0;
        clr_in();
        reset = 1'b0;
        #3;
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_state", 32'(dut.state), 32'(RUN));
        check("rst_outs", 32'(outs), 32'(O_RUN));
        @(posedge clk);
        #1;
        reset = 1'b1;

        set_lu();
        #1 check("lu_rs", 32'(outs), 32'(O_LU));
        tick(1);
        ID_EX_MemRd = 1'b0;
        #1 check("lu_bubble", 32'(outs), 32'(O_RUN));
        check("lu_cnt", 32'(stall_cnt), 32'(exp_stall));
        ID_EX_MemRd = 1'b1; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd8;
        #1 check("lu_rt", 32'(outs), 32'(O_LU));
        ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0;
        #1 check("lu_r0", 32'(outs), 32'(O_RUN));
        ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd4;
        #1 check("lu_nomatch", 32'(outs), 32'(O_RUN));
        tick(0);

        clr_in(); jump = 1'b1;
        #1 check("jump", 32'(outs), 32'(O_JMP));
        jump = 1'b0; branch_taken = 1'b1;
        #1 check("branch", 32'(outs), 32'(O_BR));
        set_lu(); jump = 1'b1;
        #1 check("br_lu_jmp", 32'(outs), 32'(O_BR));
        branch_taken = 1'b0;
        #1 check("lu_jmp", 32'(outs), 32'(O_LU));
        tick(1);
        check("cnt_after_lu", 32'(stall_cnt), 32'(exp_stall));

        clr_in();
        pulse_reset();
        check("rst_pulse_cnt", 32'(stall_cnt), 32'd0);
        EX_MEM_MemRd = 1'b1;
        #1 check("frz_run", 32'(outs), 32'(O_FRZ));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("frz_state", 32'(dut.state), 32'(MEM_WAIT));
            if (i < 2) check("frz_outs", 32'(outs), 32'(O_FRZ));
        end
        check("frz_cnt3", 32'(stall_cnt), 32'd3);
        mem_ready = 1'b1;
        #1 check("ready_outs", 32'(outs), 32'(O_RUN));
        tick(0);
        check("ready_state", 32'(dut.state), 32'(RUN));
        check("ready_cnt", 32'(stall_cnt), 32'd3);

        EX_MEM_MemRd = 1'b0; EX_MEM_MemWr = 1'b1; mem_ready = 1'b0;
        tick(1);
        mem_ready = 1'b1; branch_taken = 1'b1;
        #1 check("ready_branch", 32'(outs), 32'(O_BR));
        tick(0);
        check("ready_br_state", 32'(dut.state), 32'(RUN));
        branch_taken = 1'b0; mem_ready = 1'b0;
        tick(1);
        check("wr_wait_state", 32'(dut.state), 32'(MEM_WAIT));
        EX_MEM_MemWr = 1'b0;
        #1 check("acc_drop_outs", 32'(outs), 32'(O_RUN));
        tick(0);
        check("acc_drop_state", 32'(dut.state), 32'(RUN));
        check("acc_drop_cnt", 32'(stall_cnt), 32'd5);

        clr_in();
        pulse_reset();
        set_lu();
        repeat (20) tick(1);
        check("sat_cnt", 32'(stall_cnt), 32'd15);
        check("sat_model", 32'(exp_stall), 32'(stall_cnt));
        check("sat_outs", 32'(outs), 32'(O_LU));

        clr_in();
        pulse_reset();
        EX_MEM_MemRd = 1'b1;
        tick(1);
        tick(1);
        check("mid_state", 32'(dut.state), 32'(MEM_WAIT));
        check("mid_cnt", 32'(stall_cnt), 32'd2);
        #2 reset = 1'b0;
        #1 check("async_state", 32'(dut.state), 32'(RUN));
        check("async_cnt", 32'(stall_cnt), 32'd0);
        check("async_outs", 32'(outs), 32'(O_FRZ));
        @(posedge clk);
        #1 check("held_state", 32'(dut.state), 32'(RUN));
        check("held_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b1;
        exp_stall = 0;

`ifdef MEM_TIMEOUT_EN
        clr_in();
        pulse_reset();
        check("to_rst", 32'(mem_timeout), 32'd0);
        EX_MEM_MemRd = 1'b1;
        repeat (4) tick(1);
        check("to_pre", 32'(mem_timeout), 32'd0);
        check("to_pre_state", 32'(dut.state), 32'(MEM_WAIT));
        tick(1);
        check("to_set", 32'(mem_timeout), 32'd1);
        check("to_state", 32'(dut.state), 32'(ERROR));
        mem_ready = 1'b1;
        #1 check("err_outs", 32'(outs), 32'(O_FRZ));
        tick(1);
        check("to_sticky", 32'(mem_timeout), 32'd1);
        EX_MEM_MemRd = 1'b0; mem_ready = 1'b0; branch_taken = 1'b1;
        #1 check("err_branch", 32'(outs), 32'(O_FRZ));
        pulse_reset();
        check("to_clr", 32'(mem_timeout), 32'd0);
        check("to_clr_state", 32'(dut.state), 32'(RUN));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 16, meaning the maximum number of consecutive memory-wait cycles before a timeout.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 Ports SHALL be exactly as follows (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_EX_MemRd  in  1  the instruction in EX is a load.
- ID_EX_Rt  in  5  load destination register.
- IF_ID_Rs  in  5  ID-stage source register 1.
- IF_ID_Rt  in  5  ID-stage source register 2.
- EX_MEM_MemRd  in  1  a memory read is in the MEM stage.
- EX_MEM_MemWr  in  1  a memory write is in the MEM stage.
- mem_ready  in  1  the memory access completes this cycle.
- branch_taken  in  1  the branch resolved in EX is taken.
- jump  in  1  jump decoded in ID.
- PC_write  out  1  PC update enable.
- IF_ID_write  out  1  IF/ID register enable.
- IF_ID_flush  out  1  IF/ID register clears to a bubble.
- ID_EX_write  out  1  ID/EX register enable.
- ID_EX_flush  out  1  ID/EX register clears to a bubble.
- EX_MEM_hold  out  1  EX/MEM register holds its value.
- stall_cnt  out  CNT_W  saturating count of cycles with PC_write=0.
- mem_timeout  out  1  sticky timeout flag (present only with the macro).

Function
REQ-004 Define mem_acc = EX_MEM_MemRd | EX_MEM_MemWr.
REQ-005 Define load_use = ID_EX_MemRd & (ID_EX_Rt != 0) & (ID_EX_Rt == IF_ID_Rs | ID_EX_Rt == IF_ID_Rt).
REQ-006 The state machine SHALL have states RUN, MEM_WAIT and ERROR, and all outputs other than stall_cnt and mem_timeout SHALL be combinational from the current state and inputs.
REQ-007 Freeze = mem_acc & ~mem_ready in RUN or MEM_WAIT; during freeze, PC_write, IF_ID_write and ID_EX_write SHALL be 0, EX_MEM_hold SHALL be 1, and both flushes SHALL be 0.
REQ-008 If there is no freeze and branch_taken=1, then IF_ID_flush=1, ID_EX_flush=1 and all writes=1, and load_use and jump SHALL be ignored.
REQ-009 Else if load_use=1, then PC_write=0, IF_ID_write=0, ID_EX_flush=1 and ID_EX_write=1 (one bubble), and jump SHALL be ignored.
REQ-010 Else if jump=1, then IF_ID_flush=1 and all writes=1.
REQ-011 Otherwise all writes SHALL be 1, all flushes 0 and EX_MEM_hold 0.
REQ-012 Transitions SHALL be:
- RUN->MEM_WAIT on freeze.
- MEM_WAIT->RUN on mem_ready=1, and the priority logic of REQ-008 to REQ-011 applies in that same cycle.
- MEM_WAIT->RUN if mem_acc drops; this is a protocol violation that the design tolerates.
REQ-013 The wait counter SHALL clear on entry to MEM_WAIT and SHALL increment each cycle in MEM_WAIT.
REQ-014 stall_cnt SHALL increment on every cycle with PC_write=0, SHALL saturate at all-ones and SHALL never wrap.
REQ-015 The latency from an input change to the control outputs SHALL be zero cycles; state and counters SHALL update on the rising edge of clk.

Reset
REQ-016 Asserting reset low SHALL immediately force state=RUN, wait counter=0, stall_cnt=0 and mem_timeout=0, regardless of clk.
REQ-017 While in reset, the outputs SHALL decode as RUN with current inputs; an access in progress when reset asserts is abandoned.

Configuration
REQ-018 With MEM_TIMEOUT_EN defined:
- MEM_WAIT->ERROR occurs when the wait counter reaches WAIT_LIMIT-1 with mem_ready=0.
- ERROR is sticky until reset, with all writes=0, EX_MEM_hold=1 and mem_timeout=1.
REQ-019 Without MEM_TIMEOUT_EN:
- The ERROR state, the timeout compare and the mem_timeout port SHALL be absent.
- MEM_WAIT waits indefinitely.
- The wait counter SHALL still count but SHALL saturate at its maximum value.

Structure
REQ-020 Package hazard_pkg SHALL hold the state encoding (RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10) and the defaults for WAIT_LIMIT and CNT_W.
REQ-021 One sub-module, load_use_detect, SHALL compute load_use combinationally; everything else SHALL reside in hazard_ctrl.

Verification
REQ-022 A load to $8 in EX with $8 as Rs in ID SHALL give exactly one cycle of PC_write=0 and ID_EX_flush=1; with ID_EX_Rt=0 it SHALL give no stall.
REQ-023 EX_MEM_MemRd=1 with mem_ready low for 3 cycles SHALL give a freeze on those 3 cycles, state=MEM_WAIT, stall_cnt=3, and RUN with writes=1 on the ready cycle.
REQ-024 branch_taken=1 together with load_use=1 and jump=1 SHALL give IF_ID_flush=1, ID_EX_flush=1 and PC_write=1.
REQ-025 With MEM_TIMEOUT_EN defined, WAIT_LIMIT=4 and mem_ready held low, mem_timeout SHALL be 1 after 4 wait cycles, remain so with mem_ready=1, and clear only on reset.
REQ-026 With CNT_W=4, 20 stall cycles SHALL give stall_cnt=15; asserting reset mid-wait SHALL give state=RUN and stall_cnt=0 immediately.
